// File: rtl/lift_call_encoder.sv
// Hall-call front end: latches up/down presses, issues one pending call round-robin, clears it once the lift parks there.
// Latency: press at edge n shows in pending after n; req_valid rises after edge n+1. req/req_valid/served are registered.
// No backpressure: presses are level-ORed into pending; a held call ends on arrival, timeout or reset.
module lift_call_encoder #(
  parameter int ARRIVE_CYC = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [2:0] btn_up_i,
  input  logic [2:0] btn_dn_i,
  input  logic [1:0] cur_floor_i,
  output logic [2:0] req_o,
  output logic       req_valid_o,
  output logic [5:0] pending_o,
  output logic       served_o
);

  localparam int AW = $clog2(ARRIVE_CYC + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [5:0]      pending_q, pending_d;
  logic [2:0]      sel_q, sel_d;
  logic [2:0]      rr_q, rr_d;
  logic [AW-1:0]   arr_q, arr_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [2:0]      req_q, req_d;
  logic            req_vld_q, req_vld_d;
  logic            served_q, served_d;

  logic [5:0]      clr;
  logic            found;
  logic [2:0]      pick;
  logic [2:0]      cand;
  logic            at_target;

  // Pending index -> call code seen by the controller.
  function automatic logic [2:0] code_of(input logic [2:0] idx);
    case (idx)
      3'd0:    code_of = 3'b001;  // 1U
      3'd1:    code_of = 3'b010;  // 2U
      3'd2:    code_of = 3'b011;  // 3U
      3'd3:    code_of = 3'b110;  // 2D
      3'd4:    code_of = 3'b111;  // 3D
      3'd5:    code_of = 3'b100;  // 4D
      default: code_of = 3'b000;
    endcase
  endfunction

  // Pending index -> floor the lift must park at to serve it.
  function automatic logic [1:0] target_of(input logic [2:0] idx);
    case (idx)
      3'd0:       target_of = 2'b00;
      3'd1, 3'd3: target_of = 2'b01;
      3'd2, 3'd4: target_of = 2'b10;
      3'd5:       target_of = 2'b11;
      default:    target_of = 2'b00;
    endcase
  endfunction

  // Next-state, round-robin pick, counters and pending update.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    arr_d     = arr_q;
    wait_d    = wait_q;
    req_d     = req_q;
    req_vld_d = req_vld_q;
    served_d  = 1'b0;
    clr       = 6'b0;
    found     = 1'b0;
    pick      = 3'd0;
    cand      = 3'd0;
    at_target = (cur_floor_i == target_of(sel_q));

    // First set bit starting just after the last call handled.
    for (int off = 1; off <= 6; off++) begin
      cand = 3'(({29'd0, rr_q} + 32'(off)) % 32'd6);
      if (!found && pending_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    case (state_q)
      S_IDLE: begin
        req_d     = 3'b000;
        req_vld_d = 1'b0;
        if (found) begin
          sel_d     = pick;
          req_d     = code_of(pick);
          req_vld_d = 1'b1;
          arr_d     = '0;
          wait_d    = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (at_target) begin
          arr_d = (arr_q == AW'(ARRIVE_CYC)) ? arr_q : arr_q + AW'(1);
        end else begin
          arr_d = '0;
        end
        wait_d = (wait_q == WW'(TIMEOUT)) ? wait_q : wait_q + WW'(1);
        // Arrival is checked first so it wins over a simultaneous timeout.
        if (at_target && (arr_q == AW'(ARRIVE_CYC - 1))) begin
          clr       = 6'b000001 << sel_q;
          served_d  = 1'b1;
          rr_d      = sel_q;
          req_d     = 3'b000;
          req_vld_d = 1'b0;
          state_d   = S_IDLE;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          // Abandon for now; the call stays pending and comes round again.
          rr_d      = sel_q;
          req_d     = 3'b000;
          req_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        req_d     = 3'b000;
        req_vld_d = 1'b0;
      end
    endcase

    // A clear beats a press of the same bit: the lift is already there.
    pending_d = (pending_q | {btn_dn_i, btn_up_i}) & ~clr;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      pending_q <= 6'b0;
      sel_q     <= 3'd0;
      rr_q      <= 3'd5;
      arr_q     <= '0;
      wait_q    <= '0;
      req_q     <= 3'b000;
      req_vld_q <= 1'b0;
      served_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
      arr_q     <= arr_d;
      wait_q    <= wait_d;
      req_q     <= req_d;
      req_vld_q <= req_vld_d;
      served_q  <= served_d;
    end
  end

  assign req_o       = req_q;
  assign req_valid_o = req_vld_q;
  assign pending_o   = pending_q;
  assign served_o    = served_q;

endmodule

// File: tb/tb_lift_call_encoder.sv
// Bench for lift_call_encoder: directed scenarios plus random traffic against a call-level model.
// Inputs change on the falling edge; outputs are compared 1 time unit after each rising edge.
// Literal expectations posted by the stimulus pin the model on the directed scenarios.
module tb_lift_call_encoder;

  localparam int ARRIVE  = 4;
  localparam int TIMEOUT = 64;

  logic       clk;
  logic       rst_n;
  logic [2:0] btn_up;
  logic [2:0] btn_dn;
  logic [1:0] cur_floor;
  logic [2:0] req;
  logic       req_valid;
  logic [5:0] pending;
  logic       served;

  lift_call_encoder #(.ARRIVE_CYC(ARRIVE), .TIMEOUT(TIMEOUT)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .btn_up_i    (btn_up),
    .btn_dn_i    (btn_dn),
    .cur_floor_i (cur_floor),
    .req_o       (req),
    .req_valid_o (req_valid),
    .pending_o   (pending),
    .served_o    (served)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors;
  int miscompares;

  // Call tables indexed by pending bit: 1U 2U 3U 2D 3D 4D.
  int code_tab [6] = '{1, 2, 3, 6, 7, 4};
  int tgt_tab  [6] = '{0, 1, 2, 1, 2, 3};

  // Model state: which call is held, how long, and how long the lift has been parked on it.
  logic [5:0] m_pend;
  int         m_req;
  logic       m_vld;
  logic       m_srv;
  int         m_rr;
  logic       m_busy;
  int         m_sel;
  int         m_age;
  int         m_streak;
  logic       m_live;
  logic [5:0] m_clr;
  logic       m_srv_n;
  int         m_idx;
  logic       m_got;

  // Literal expectations posted by the stimulus for the result of the next rising edge.
  string      lit_name;
  logic [2:0] lit_req;
  logic       lit_vld;
  logic [5:0] lit_pend;
  logic       lit_srv;
  int         lit_seq;
  int         lit_done;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update and comparison, once per rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend = 6'b0; m_req = 0; m_vld = 1'b0; m_srv = 1'b0;
      m_rr = 5; m_busy = 1'b0; m_sel = 0; m_age = 0; m_streak = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      m_clr = 6'b0;
      m_srv_n = 1'b0;
      if (!m_busy) begin
        m_req = 0;
        m_vld = 1'b0;
        m_got = 1'b0;
        for (int k = 1; k <= 6; k++) begin
          m_idx = (m_rr + k) % 6;
          if (!m_got && m_pend[m_idx]) begin
            m_got = 1'b1;
            m_sel = m_idx;
            m_busy = 1'b1;
            m_age = 0;
            m_streak = 0;
            m_req = code_tab[m_idx];
            m_vld = 1'b1;
          end
        end
      end else begin
        m_age = m_age + 1;
        if (int'(cur_floor) == tgt_tab[m_sel]) m_streak = m_streak + 1;
        else m_streak = 0;
        if (m_streak == ARRIVE) begin
          m_clr[m_sel] = 1'b1;
          m_srv_n = 1'b1;
          m_rr = m_sel;
          m_busy = 1'b0;
          m_req = 0;
          m_vld = 1'b0;
        end else if (m_age == TIMEOUT) begin
          m_rr = m_sel;
          m_busy = 1'b0;
          m_req = 0;
          m_vld = 1'b0;
        end
      end
      m_pend = (m_pend | {btn_dn, btn_up}) & ~m_clr;
      m_srv = m_srv_n;
    end

    #1;
    if (m_live) begin
      chk("req",       8'(req),       8'(m_req));
      chk("req_valid", 8'(req_valid), 8'(m_vld));
      chk("pending",   8'(pending),   8'(m_pend));
      chk("served",    8'(served),    8'(m_srv));
      chk("served_and_valid", 8'(served & req_valid), 8'd0);
    end
    if (lit_seq != lit_done) begin
      lit_done = lit_seq;
      chk({lit_name, "_req"},     8'(req),       8'(lit_req));
      chk({lit_name, "_valid"},   8'(req_valid), 8'(lit_vld));
      chk({lit_name, "_pending"}, 8'(pending),   8'(lit_pend));
      chk({lit_name, "_served"},  8'(served),    8'(lit_srv));
    end
  end

  task automatic step(input logic r, input logic [2:0] u, input logic [2:0] d, input logic [1:0] f);
    rst_n = r;
    btn_up = u;
    btn_dn = d;
    cur_floor = f;
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic [2:0] rq, input logic v, input logic [5:0] pd, input logic s);
    lit_name = nm;
    lit_req = rq;
    lit_vld = v;
    lit_pend = pd;
    lit_srv = s;
    lit_seq++;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    lit_seq = 0;
    lit_done = 0;
    m_live = 1'b0;
    lit_name = "";
    lit_req = 3'b0; lit_vld = 1'b0; lit_pend = 6'b0; lit_srv = 1'b0;
    rst_n = 1'b0; btn_up = 3'b111; btn_dn = 3'b111; cur_floor = 2'b00;
    @(negedge clk);

    // Reset held with every button pressed.
    for (int i = 0; i < 3; i++) begin
      lit("reset", 3'b000, 1'b0, 6'b0, 1'b0);
      step(1'b0, 3'b111, 3'b111, 2'b00);
    end
    lit("release", 3'b000, 1'b0, 6'b0, 1'b0);
    step(1'b1, 3'b000, 3'b000, 2'b00);

    // Single call 3U served at floor F3.
    lit("press3u", 3'b000, 1'b0, 6'b000100, 1'b0);
    step(1'b1, 3'b100, 3'b000, 2'b00);
    lit("issue3u", 3'b011, 1'b1, 6'b000100, 1'b0);
    step(1'b1, 3'b000, 3'b000, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 3'b000, 2'b10);
    lit("serve3u", 3'b000, 1'b0, 6'b000000, 1'b1);
    step(1'b1, 3'b000, 3'b000, 2'b10);
    lit("after3u", 3'b000, 1'b0, 6'b000000, 1'b0);
    step(1'b1, 3'b000, 3'b000, 2'b10);

    // Round-robin from a fresh reset: 1U before 4D.
    step(1'b0, 3'b000, 3'b000, 2'b00);
    step(1'b1, 3'b001, 3'b100, 2'b00);
    lit("rr_first", 3'b001, 1'b1, 6'b100001, 1'b0);
    step(1'b1, 3'b000, 3'b000, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 3'b000, 2'b00);
    lit("rr_serve1u", 3'b000, 1'b0, 6'b100000, 1'b1);
    step(1'b1, 3'b000, 3'b000, 2'b00);
    lit("rr_second", 3'b100, 1'b1, 6'b100000, 1'b0);
    step(1'b1, 3'b000, 3'b000, 2'b00);

    // Timeout on 2D with the lift parked at F1.
    step(1'b0, 3'b000, 3'b000, 2'b00);
    step(1'b1, 3'b000, 3'b001, 2'b00);
    lit("to_issue", 3'b110, 1'b1, 6'b001000, 1'b0);
    step(1'b1, 3'b000, 3'b000, 2'b00);
    for (int i = 0; i < TIMEOUT - 1; i++) step(1'b1, 3'b000, 3'b000, 2'b00);
    lit("to_drop", 3'b000, 1'b0, 6'b001000, 1'b0);
    step(1'b1, 3'b000, 3'b000, 2'b00);
    lit("to_reissue", 3'b110, 1'b1, 6'b001000, 1'b0);
    step(1'b1, 3'b000, 3'b000, 2'b00);
    for (int i = 0; i < 6; i++) step(1'b1, 3'b000, 3'b000, 2'b00);

    // Clear beats a held press of the same button.
    step(1'b0, 3'b000, 3'b000, 2'b00);
    step(1'b1, 3'b001, 3'b000, 2'b00);
    lit("cvp_issue", 3'b001, 1'b1, 6'b000001, 1'b0);
    step(1'b1, 3'b001, 3'b000, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b1, 3'b001, 3'b000, 2'b00);
    lit("cvp_serve", 3'b000, 1'b0, 6'b000000, 1'b1);
    step(1'b1, 3'b001, 3'b000, 2'b00);
    lit("cvp_reset", 3'b000, 1'b0, 6'b000001, 1'b0);
    step(1'b1, 3'b001, 3'b000, 2'b00);
    lit("cvp_again", 3'b001, 1'b1, 6'b000001, 1'b0);
    step(1'b1, 3'b000, 3'b000, 2'b00);

    // Reset while 3D is held.
    step(1'b0, 3'b000, 3'b000, 2'b00);
    step(1'b1, 3'b000, 3'b010, 2'b00);
    lit("mid_issue", 3'b111, 1'b1, 6'b010000, 1'b0);
    step(1'b1, 3'b000, 3'b000, 2'b10);
    step(1'b1, 3'b000, 3'b000, 2'b10);
    lit("mid_reset", 3'b000, 1'b0, 6'b000000, 1'b0);
    step(1'b0, 3'b000, 3'b000, 2'b10);
    lit("mid_after", 3'b000, 1'b0, 6'b000000, 1'b0);
    step(1'b1, 3'b000, 3'b000, 2'b10);

    // Random traffic: sparse presses, a lift that lingers on floors, rare resets.
    begin
      logic [2:0] u;
      logic [2:0] d;
      logic [1:0] f;
      logic       r;
      f = 2'b00;
      for (int c = 0; c < 4000; c++) begin
        for (int b = 0; b < 3; b++) begin
          u[b] = ($urandom_range(0, 19) == 0);
          d[b] = ($urandom_range(0, 19) == 0);
        end
        if ($urandom_range(0, 5) == 0) f = 2'($urandom_range(0, 3));
        r = ($urandom_range(0, 599) != 0);
        step(r, u, d, f);
      end
    end

    step(1'b1, 3'b000, 3'b000, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
